// File: rtl/fifo_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pattern_loader
// Description : Burst pattern generator. On a rising edge of start it writes
//               burst_len words into a FIFO, following one of four pattern
//               modes (INC, CONST, LFSR, DEC). It then raises a sticky drain
//               enable for the FIFO-to-UART path. The pattern register keeps
//               its value from one burst to the next.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pattern_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LEN_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 8'h41,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  seed_load,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  drain_clr,
  input  logic                  fifo_busy,
  input  logic                  fifo_full,
  output logic                  fifo_we,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  drain_en,
  output logic                  done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] value,
  output logic [LEN_WIDTH-1:0]  words_written
);

  // Pattern mode encodings
  localparam logic [1:0] c_MODE_INC   = 2'd0;
  localparam logic [1:0] c_MODE_CONST = 2'd1;
  localparam logic [1:0] c_MODE_LFSR  = 2'd2;
  localparam logic [1:0] c_MODE_DEC   = 2'd3;

  // An LFSR stuck at zero would never leave zero, so it is restarted at one
  localparam logic [DATA_WIDTH-1:0] c_LFSR_RESTART = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  c_LEN_ONE      = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_WRITE   = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4,
    S_REARM   = 3'd5
  } state_t;

  state_t                state_q,     state_d;
  logic                  start_q,     start_d;
  logic [LEN_WIDTH-1:0]  len_q,       len_d;
  logic [1:0]            mode_q,      mode_d;
  logic [DATA_WIDTH-1:0] step_q,      step_d;
  logic [DATA_WIDTH-1:0] value_q,     value_d;
  logic [LEN_WIDTH-1:0]  words_q,     words_d;
  logic                  fifo_we_q,   fifo_we_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic                  drain_en_q,  drain_en_d;
  logic                  done_q,      done_d;

  logic                  start_edge;
  logic                  stalled;
  logic [LEN_WIDTH-1:0]  words_inc;
  logic [DATA_WIDTH-1:0] lfsr_next;
  logic [DATA_WIDTH-1:0] pattern_next;

  // Pattern arithmetic for the word just written, selected by the latched mode
  always_comb begin
    start_edge = start & ~start_q;
    stalled    = fifo_busy | fifo_full;
    words_inc  = words_q + c_LEN_ONE;
    lfsr_next  = {value_q[DATA_WIDTH-2:0], 1'b0} ^
                 (value_q[DATA_WIDTH-1] ? LFSR_TAPS : {DATA_WIDTH{1'b0}});
    pattern_next = value_q;
    case (mode_q)
      c_MODE_INC:   pattern_next = value_q + step_q;
      c_MODE_CONST: pattern_next = value_q;
      c_MODE_LFSR:  pattern_next = lfsr_next;
      c_MODE_DEC:   pattern_next = value_q - step_q;
      default:      pattern_next = value_q;
    endcase
  end

  // Next-state logic and burst bookkeeping
  always_comb begin
    state_d = state_q;
    start_d = start;
    len_d   = len_q;
    mode_d  = mode_q;
    step_d  = step_q;
    value_d = value_q;
    words_d = words_q;

    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          // Seeding wins over a coincident start edge; that edge is lost
          value_d = seed;
        end else if (start_edge) begin
          len_d   = burst_len;
          mode_d  = mode;
          step_d  = step;
          words_d = '0;
          if ((mode == c_MODE_LFSR) && (value_q == '0)) begin
            value_d = c_LFSR_RESTART;
          end
          state_d = (burst_len == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!stalled) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        words_d = words_inc;
        value_d = pattern_next;
        state_d = (words_inc == len_q) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        state_d = S_REARM;
      end
      S_REARM: begin
        // Hold here until the button is released: one burst per press
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort freezes the counters where they are and drops straight to IDLE
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      value_d = value_q;
      words_d = words_q;
    end
  end

  // Registered outputs, derived from the state being entered
  always_comb begin
    fifo_we_d   = (state_d == S_WRITE);
    fifo_data_d = (state_d == S_WRITE) ? value_q : fifo_data_q;
    done_d      = (state_d == S_DONE) && (state_q != S_DONE);
    drain_en_d  = drain_en_q;
    if ((state_q == S_DONE) && !abort) begin
      drain_en_d = 1'b1;
    end else if (drain_clr) begin
      drain_en_d = 1'b0;
    end
  end

  // State and data registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      len_q       <= '0;
      mode_q      <= c_MODE_INC;
      step_q      <= '0;
      value_q     <= INIT_VALUE;
      words_q     <= '0;
      fifo_we_q   <= 1'b0;
      fifo_data_q <= '0;
      drain_en_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      value_q     <= value_d;
      words_q     <= words_d;
      fifo_we_q   <= fifo_we_d;
      fifo_data_q <= fifo_data_d;
      drain_en_q  <= drain_en_d;
      done_q      <= done_d;
    end
  end

  assign fifo_we       = fifo_we_q;
  assign fifo_data     = fifo_data_q;
  assign drain_en      = drain_en_q;
  assign done          = done_q;
  assign busy          = (state_q != S_IDLE);
  assign value         = value_q;
  assign words_written = words_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_pattern_loader
// Description : Self-checking bench for fifo_pattern_loader. Vector table of
//               bursts plus directed back-pressure, abort, rearm and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pattern_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [7:0] step;
  logic [7:0] burst_len;
  logic       seed_load;
  logic [7:0] seed;
  logic       drain_clr;
  logic       fifo_busy;
  logic       fifo_full;
  logic       fifo_we;
  logic [7:0] fifo_data;
  logic       drain_en;
  logic       done;
  logic       busy;
  logic [7:0] value;
  logic [7:0] words_written;

  int checks   = 0;
  int failures = 0;

  fifo_pattern_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .step         (step),
    .burst_len    (burst_len),
    .seed_load    (seed_load),
    .seed         (seed),
    .drain_clr    (drain_clr),
    .fifo_busy    (fifo_busy),
    .fifo_full    (fifo_full),
    .fifo_we      (fifo_we),
    .fifo_data    (fifo_data),
    .drain_en     (drain_en),
    .done         (done),
    .busy         (busy),
    .value        (value),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      m;
    logic [7:0]      st;
    logic [7:0]      len;
    logic            sl;
    logic [7:0]      sd;
    logic [3:0][7:0] ew;
    int              en;
    logic [7:0]      ev;
    int              ed;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_seed(input logic [7:0] s);
    seed_load = 1'b1;
    seed      = s;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Starts a burst at the current negedge (cycle 0) and observes a fixed
  // window. Cycle k is the cycle following the k-th rising edge after start.
  task automatic run_burst(input string nm, input logic [1:0] m, input logic [7:0] st,
                           input logic [7:0] len, input int hold,
                           input int bf, input int bt, input int ff, input int ft,
                           input int ab, input logic [3:0][7:0] ew,
                           input int en, input int ed, input int ncyc);
    int   nw;
    int   nd;
    int   drel;
    int   viol;
    logic prev_stall;
    nw = 0; nd = 0; drel = 0; viol = 0;
    mode = m; step = st; burst_len = len; start = 1'b1;
    fifo_busy = 1'b0; fifo_full = 1'b0; abort = 1'b0;
    prev_stall = 1'b0;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(negedge clk);
      if (fifo_we) begin
        if (prev_stall) viol++;
        if (nw < 4) chk($sformatf("%s word%0d", nm, nw), {24'h0, fifo_data}, {24'h0, ew[nw]});
        nw++;
      end
      if (done) begin
        nd++;
        if (drel == 0) drel = rel;
      end
      if (ab > 0 && rel == ab + 1) chk({nm, " busy_after_abort"}, {31'h0, busy}, 32'h0);
      start     = (rel < hold);
      fifo_busy = (rel >= bf) && (rel <= bt);
      fifo_full = (rel >= ff) && (rel <= ft);
      abort     = (ab > 0) && (rel == ab);
      if (rel == 2) begin
        mode = ~m; step = 8'h55; burst_len = 8'hAA;
      end
      prev_stall = fifo_busy | fifo_full;
    end
    start = 1'b0; fifo_busy = 1'b0; fifo_full = 1'b0; abort = 1'b0;
    chk({nm, " nwords"}, nw, en);
    chk({nm, " ndone"}, nd, (ed > 0) ? 1 : 0);
    chk({nm, " done_cycle"}, drel, ed);
    chk({nm, " we_while_stalled"}, viol, 0);
  endtask

  initial begin
    int found;
    vt[0] = '{2'd0, 8'd1,  8'd3, 1'b0, 8'h00, {8'h00, 8'h43, 8'h42, 8'h41}, 3, 8'h44, 10};
    vt[1] = '{2'd2, 8'd0,  8'd4, 1'b1, 8'h00, {8'h08, 8'h04, 8'h02, 8'h01}, 4, 8'h10, 13};
    vt[2] = '{2'd2, 8'd0,  8'd3, 1'b1, 8'h80, {8'h00, 8'hC8, 8'hB8, 8'h80}, 3, 8'h28, 10};
    vt[3] = '{2'd3, 8'd3,  8'd2, 1'b1, 8'h02, {8'h00, 8'h00, 8'hFF, 8'h02}, 2, 8'hFC, 7};
    vt[4] = '{2'd1, 8'd9,  8'd2, 1'b0, 8'h00, {8'h00, 8'h00, 8'hFC, 8'hFC}, 2, 8'hFC, 7};
    vt[5] = '{2'd0, 8'h10, 8'd1, 1'b0, 8'h00, {8'h00, 8'h00, 8'h00, 8'hFC}, 1, 8'h0C, 4};

    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; step = 8'd0;
    burst_len = 8'd0; seed_load = 1'b0; seed = 8'd0; drain_clr = 1'b0;
    fifo_busy = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst fifo_we",   {31'h0, fifo_we},  32'h0);
    chk("rst fifo_data", {24'h0, fifo_data}, 32'h0);
    chk("rst drain_en",  {31'h0, drain_en}, 32'h0);
    chk("rst done",      {31'h0, done},     32'h0);
    chk("rst busy",      {31'h0, busy},     32'h0);
    chk("rst value",     {24'h0, value},    32'h41);
    chk("rst words",     {24'h0, words_written}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Vector table: bursts applied back to back, pattern carries over
    for (int i = 0; i < 6; i++) begin
      if (vt[i].sl) do_seed(vt[i].sd);
      run_burst($sformatf("vec%0d", i), vt[i].m, vt[i].st, vt[i].len, 1,
                0, -1, 0, -1, 0, vt[i].ew, vt[i].en, vt[i].ed, vt[i].ed + 3);
      chk($sformatf("vec%0d value", i), {24'h0, value}, {24'h0, vt[i].ev});
      chk($sformatf("vec%0d words", i), {24'h0, words_written}, vt[i].en);
      chk($sformatf("vec%0d drain_en", i), {31'h0, drain_en}, 32'h1);
      chk($sformatf("vec%0d idle", i), {31'h0, busy}, 32'h0);
    end

    // Back-pressure: busy for 5 cycles on word 1, full for 2 on word 2
    do_seed(8'h41);
    run_burst("bp", 2'd0, 8'd1, 8'd3, 1, 1, 5, 9, 10, 0,
              {8'h00, 8'h43, 8'h42, 8'h41}, 3, 17, 20);
    chk("bp value", {24'h0, value}, 32'h44);

    // Abort in the second WAIT of a 4-word burst
    do_seed(8'h41);
    run_burst("abort", 2'd0, 8'd1, 8'd4, 1, 0, -1, 0, -1, 4,
              {8'h00, 8'h00, 8'h00, 8'h41}, 1, 0, 8);
    chk("abort value", {24'h0, value}, 32'h42);
    chk("abort words", {24'h0, words_written}, 32'h1);
    chk("abort drain_en kept", {31'h0, drain_en}, 32'h1);

    // drain_clr, then zero-length burst with start held for 20 cycles
    drain_clr = 1'b1;
    @(negedge clk);
    drain_clr = 1'b0;
    chk("drain_clr", {31'h0, drain_en}, 32'h0);
    run_burst("zero", 2'd0, 8'd1, 8'd0, 20, 0, -1, 0, -1, 0,
              {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 25);
    chk("zero drain_en", {31'h0, drain_en}, 32'h1);
    chk("zero idle", {31'h0, busy}, 32'h0);

    // Asynchronous reset asserted between edges while fifo_we is high
    mode = 2'd0; step = 8'd1; burst_len = 8'd3; start = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (fifo_we) found = 1;
    end
    chk("areset reached_write", found, 1);
    chk("areset drain_pre", {31'h0, drain_en}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("areset fifo_we",  {31'h0, fifo_we},  32'h0);
    chk("areset drain_en", {31'h0, drain_en}, 32'h0);
    chk("areset value",    {24'h0, value},    32'h41);
    chk("areset busy",     {31'h0, busy},     32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("areset still_idle", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_pattern_loader.md
# fifo_pattern_loader

Parametrised burst pattern generator that writes a programmable sequence of data words into the FIFO and then enables the FIFO-to-UART drain path. It replaces hand-written per-board loader state machines with one reusable block. It sits between the button pulsers and the FIFO write port. Each start request writes a burst of N words, where the data follows one of four pattern modes. The current pattern value carries over between bursts.

## Interface
- DATA_WIDTH, 8, width of the FIFO data word and the pattern register
- LEN_WIDTH, 8, width of the burst length and the written-word counter
- INIT_VALUE, 8'h41, pattern register value after reset
- LFSR_TAPS, 8'hB8, Galois feedback mask used in LFSR mode
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  burst request as a level; only a rising edge is acted on
- abort  in  1  cancels the burst in progress
- mode  in  2  pattern mode: 0 INC, 1 CONST, 2 LFSR, 3 DEC
- step  in  DATA_WIDTH  increment/decrement amount for INC/DEC
- burst_len  in  LEN_WIDTH  number of words to write; 0 means none
- seed_load  in  1  loads seed into the pattern register, honoured only in IDLE
- seed  in  DATA_WIDTH  seed value
- drain_clr  in  1  clears drain_en
- fifo_busy  in  1  FIFO cannot accept a write this cycle
- fifo_full  in  1  FIFO full
- fifo_we  out  1  FIFO write strobe, registered
- fifo_data  out  DATA_WIDTH  word to write, registered
- drain_en  out  1  sticky enable for the FIFO-to-out and out-to-com path
- done  out  1  one-cycle pulse when a burst completes normally
- busy  out  1  high in every state except IDLE
- value  out  DATA_WIDTH  current pattern register
- words_written  out  LEN_WIDTH  words written in the current or last burst

## Operation
- **States:** IDLE, WAIT, WRITE, ADVANCE, DONE, REARM.
- **Start edge detection:** a start edge is start=1 while start_q=0. start_q is the start value registered one cycle earlier.
- **IDLE:**
  - seed_load=1 sets value to seed. If seed_load and a start edge occur in the same cycle, seed_load has priority; the start edge is discarded.
  - On a start edge, latch burst_len into len_q and latch mode into mode_q, then clear words_written.
  - If mode is LFSR and value is 0, load value with 1.
  - Next state is WAIT. If burst_len is 0, next state is DONE instead.
- **WAIT:** stay while fifo_busy=1 or fifo_full=1. Otherwise go to WRITE.
- **WRITE:** fifo_we=1 and fifo_data=value for exactly this one cycle. Next state is ADVANCE.
- **ADVANCE:**
  - words_written increments by 1.
  - value updates by mode_q:
    - INC: value + step, modulo 2^DATA_WIDTH.
    - CONST: value unchanged.
    - LFSR: shift value left by one, inserting 0. If the old MSB was 1, XOR the result with LFSR_TAPS.
    - DEC: value − step, modulo 2^DATA_WIDTH.
  - If the incremented words_written equals len_q, go to DONE. Otherwise go to WAIT.
- **DONE:** done=1 for one cycle and drain_en is set to 1. Next state is REARM.
- **REARM:** go to IDLE once start=0. This gives one burst per press.
- **abort=1 in any non-IDLE state:**
  - Next state is IDLE and fifo_we=0 on the next cycle.
  - done is not pulsed and drain_en is unchanged.
  - value and words_written keep their current contents.
  - If abort coincides with WRITE, that word has already been strobed. The pattern advance for it is skipped.
- **drain_en:** drain_clr=1 clears it in any state. If drain_clr and DONE occur in the same cycle, set wins.
- **Inputs during a burst:** mode, step and burst_len changes are ignored until the next start edge.

## Timing
- **Reset values:** state IDLE, fifo_we 0, fifo_data 0, drain_en 0, done 0, busy 0, value INIT_VALUE, words_written 0, start_q 0.
- **First write:** start edge sampled at edge n, state WAIT at n+1. If the FIFO is free, fifo_we is high during cycle n+2.
- **Word spacing:** 3 cycles per word with no stall. Each cycle of fifo_busy or fifo_full in WAIT adds one cycle.
- **Completion:** done is high the cycle after the ADVANCE of the last word. For N≥1 with no stall, done is at cycle n+1+3N.
- **Zero-length burst:** burst_len=0 gives done at n+1 with no fifo_we.
- **Back-pressure:** fifo_busy and fifo_full are sampled only in WAIT. The block never asserts fifo_we while they are high in the previous cycle.
- **Counter wrap:** words_written can reach 2^LEN_WIDTH−1 at most, so it never wraps within a burst.

## Test plan
- **Reset defaults and basic INC burst:**
  - Stimulus: reset, then INC, step=1, burst_len=3, start pulse.
  - Response: fifo_data 41,42,43 with fifo_we on cycles n+2, n+5, n+8; done at n+10; drain_en=1; value=44; words_written=3.
- **Back-pressure:**
  - Stimulus: same burst with fifo_busy held high for 5 cycles, then fifo_full for 2 cycles during the second word.
  - Response: no fifo_we while either is high; data is still 41,42,43 in order; done is delayed by exactly 7 cycles.
- **LFSR mode:**
  - Stimulus: seed_load with seed=0, then LFSR, burst_len=4.
  - Response: value forced to 01; words 01,02,04,08. A following burst starting from value 80 continues 80,B8,C8.
- **DEC wrap and CONST:**
  - Stimulus: seed=02, DEC, step=3, burst_len=2, then CONST with burst_len=2.
  - Response: DEC words 02,FF; value FC after the burst. CONST words FC,FC.
- **Abort, zero length and rearm:**
  - Stimulus: abort asserted during the second WAIT of a 4-word burst; then burst_len=0 with start held high for 20 cycles.
  - Response:
    - Abort: one word written, no done, busy=0 on the next cycle.
    - Zero-length burst: done once at n+1, no fifo_we, and only one burst until start returns to 0.
- **Asynchronous reset mid-burst:**
  - Stimulus: reset pulled low between edges during WRITE.
  - Response: fifo_we and drain_en drop immediately; value returns to 41; state is IDLE.
